traffic_light_ctrl: RTL and testbench
=====================================

# traffic_light_ctrl

- Sequencing FSM for the shared traffic-light interval counter (`counter`).
- Drives the counter's restart input `T` and reads its terminal flags `tr`, `tg_main`, `tg_small` and `ty` to step through a main-road/side-road light cycle.
- Latches side-road demand, so the main road stays green until a request exists.
- A watchdog detects a stalled counter and forces a latched flashing-red fault mode.

## Interface

Parameters:
- WDOG_CYCLES, 64, max cycles allowed in any timed state before fault (≥2)
- FLASH_HALF, 8, fault-mode flash half-period in cycles (≥1)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- tr  input  1  counter flag: all-red interval elapsed
- tg_main  input  1  counter flag: main-green minimum elapsed
- tg_small  input  1  counter flag: side-green interval elapsed
- ty  input  1  counter flag: yellow interval elapsed
- side_req  input  1  side-road car sensor; level or single-cycle pulse
- T  output  1  counter restart, registered
- main_rgy  output  3  main-road lamps {red, yellow, green}
- side_rgy  output  3  side-road lamps {red, yellow, green}
- walk  output  1  side-road pedestrian walk lamp
- fault  output  1  watchdog fault, latched until rst
- state  output  3  current FSM state encoding

## Operation

- Flags are levels from the counter. A flag is high once its interval has elapsed since the last `T`, and stays high until the next `T`.
- State encodings: MAIN_G=0, MAIN_Y=1, RED_A=2, SIDE_G=3, SIDE_Y=4, RED_B=5, FAULT=6. Encoding 7 is illegal and goes to FAULT on the next edge.
- Transitions (all flags qualified with ~T):
  - MAIN_G → MAIN_Y when tg_main & pend.
  - MAIN_Y → RED_A when ty.
  - RED_A → SIDE_G when tr.
  - SIDE_G → SIDE_Y when tg_small.
  - SIDE_Y → RED_B when ty.
  - RED_B → MAIN_G when tr.
- MAIN_G with tg_main high and pend low holds indefinitely. The watchdog is suspended in this condition only.
- `pend` register:
  - set on any cycle with side_req=1;
  - cleared on the edge entering SIDE_G;
  - if side_req=1 on that same cycle, set wins, and pend stays 1.
- `T` is registered and equals 1 for exactly the first cycle of every state entry except FAULT.
- Lamp decode, combinational from the state register:
  - MAIN_G: main=001, side=100.
  - MAIN_Y: main=010, side=100.
  - RED_A and RED_B: main=100, side=100.
  - SIDE_G: main=100, side=001, walk=1.
  - SIDE_Y: main=100, side=010.
  - FAULT: main=side={flash,0,0}, walk=0.
- Watchdog:
  - `wd` counter has width $clog2(WDOG_CYCLES+1). It clears on every state entry and increments each cycle in timed states.
  - On reaching WDOG_CYCLES without the exit flag, the next edge enters FAULT and sets `fault`=1.
- FAULT:
  - Only rst exits this state.
  - T=0 throughout.
  - `flash` starts at 1 on entry and toggles every FLASH_HALF cycles.
  - side_req is ignored and pend holds.

## Timing

- Reset values (cycle after rst high): state=MAIN_G, T=1, main_rgy=001, side_rgy=100, walk=0, fault=0, pend=0, wd=0, flash=1.
- Holding rst keeps T=1, which holds the counter cleared.
- The first cycle after rst deasserts is treated as the MAIN_G entry cycle: T=1 and flags are ignored.
- State change latency:
  - A qualified flag seen in cycle n gives the new state and T=1 in cycle n+1.
  - T=0 and flags are observed from cycle n+2.
  - Stale flags during the T=1 cycle never cause a transition.
- Minimum dwell per state is 2 cycles: the entry cycle, plus one cycle to observe a flag.
- side_req pulse timing:
  - A pulse in cycle n sets pend in cycle n+1.
  - If tg_main is already high, MAIN_Y is entered at n+2.
- rst mid-cycle in any state, including FAULT, returns to MAIN_G reset values on the next edge. A pending request is lost.
- Outputs are glitch-free: lamps decode only from registers.

## Test plan

- **Reset:** rst=1 for 2 cycles → state=0, T=1, main_rgy=001, side_rgy=100, fault=0. After release, T=1 for one more cycle, then 0.
- **Hold without demand:** side_req=0, tg_main forced 1 for 200 cycles → stays in MAIN_G, T stays 0, fault=0.
- **Full cycle:**
  - Stimulus: side_req pulse at cycle 10, counter model with tg_main=5, ty=3, tr=2, tg_small=6 cycles after T.
  - Required order: MAIN_Y → RED_A → SIDE_G (walk=1) → SIDE_Y → RED_B → MAIN_G.
  - T is a single-cycle pulse on each entry.
  - pend=0 after SIDE_G entry.
- **Stale flags:** flags held high through the T=1 cycle → no transition in that cycle; transition occurs the cycle after.
- **Simultaneous set/clear:** side_req=1 on the SIDE_G entry edge → pend remains 1, and the next main-green ends at tg_main.
- **Watchdog:**
  - Stimulus: in MAIN_Y, ty held 0 with WDOG_CYCLES=64.
  - Response: FAULT at wd=64, fault=1, main_rgy/side_rgy alternate 100/000 every 8 cycles, T=0.
  - rst then restores the reset values.

Source files
------------

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: sequencing FSM for the shared traffic-light interval counter.
// Restarts the counter with T on every state entry, steps the main/side light cycle
// from the counter's terminal flags, latches side-road demand, and falls into a
// latched flashing-red fault mode when the counter stalls.
module traffic_light_ctrl #(
  parameter int WDOG_CYCLES = 64,
  parameter int FLASH_HALF  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tr,
  input  logic       tg_main,
  input  logic       tg_small,
  input  logic       ty,
  input  logic       side_req,
  output logic       T,
  output logic [2:0] main_rgy,
  output logic [2:0] side_rgy,
  output logic       walk,
  output logic       fault,
  output logic [2:0] state
);

  localparam logic [2:0] S_MAIN_G = 3'd0;
  localparam logic [2:0] S_MAIN_Y = 3'd1;
  localparam logic [2:0] S_RED_A  = 3'd2;
  localparam logic [2:0] S_SIDE_G = 3'd3;
  localparam logic [2:0] S_SIDE_Y = 3'd4;
  localparam logic [2:0] S_RED_B  = 3'd5;
  localparam logic [2:0] S_FAULT  = 3'd6;

  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  localparam int FC_W = $clog2(FLASH_HALF + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(WDOG_CYCLES);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FLASH_HALF - 1);

  logic [2:0]      state_q, state_d, succ;
  logic            t_q, t_d;
  logic            pend_q, pend_d;
  logic            flash_q, flash_d;
  logic            fault_q, fault_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [FC_W-1:0] fc_q, fc_d;
  logic            exit_raw, advance, wd_hold, wd_expired, entering;

  // State register; reset lands in the MAIN_G entry cycle.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_MAIN_G;
    else     state_q <= state_d;
  end

  // Next state: exit flags are ignored during the T cycle because the counter
  // has not yet cleared them; a stalled counter trips the watchdog into FAULT.
  always_comb begin
    exit_raw = 1'b0;
    succ     = S_FAULT;
    case (state_q)
      S_MAIN_G: begin exit_raw = tg_main & pend_q; succ = S_MAIN_Y; end
      S_MAIN_Y: begin exit_raw = ty;               succ = S_RED_A;  end
      S_RED_A:  begin exit_raw = tr;               succ = S_SIDE_G; end
      S_SIDE_G: begin exit_raw = tg_small;         succ = S_SIDE_Y; end
      S_SIDE_Y: begin exit_raw = ty;               succ = S_RED_B;  end
      S_RED_B:  begin exit_raw = tr;               succ = S_MAIN_G; end
      default:  ;
    endcase
    advance    = exit_raw & ~t_q;
    // Main green with its minimum served and no demand is a legitimate idle hold.
    wd_hold    = (state_q == S_MAIN_G) & ~t_q & tg_main & ~pend_q;
    wd_expired = (wd_q == WD_MAX) & ~wd_hold;
    state_d    = state_q;
    if (state_q == S_FAULT || state_q == 3'd7) state_d = S_FAULT;
    else if (advance)                          state_d = succ;
    else if (wd_expired)                       state_d = S_FAULT;
  end

  // Next values of the control registers that travel with the FSM.
  always_comb begin
    entering = (state_d != state_q);
    t_d      = entering & (state_d != S_FAULT);
    fault_d  = fault_q | (state_d == S_FAULT);

    // Demand latch: a request on the SIDE_G entry edge survives the clear.
    pend_d = pend_q;
    if (state_q != S_FAULT) begin
      if (side_req)                              pend_d = 1'b1;
      else if (entering && state_d == S_SIDE_G)  pend_d = 1'b0;
    end

    wd_d = wd_q;
    if (entering || state_q == S_FAULT) wd_d = '0;
    else if (!wd_hold && wd_q != WD_MAX) wd_d = wd_q + 1'b1;

    // Flash phase starts lit on FAULT entry and toggles every FLASH_HALF cycles.
    flash_d = 1'b1;
    fc_d    = '0;
    if (state_q == S_FAULT) begin
      if (fc_q == FC_LAST) begin
        flash_d = ~flash_q;
        fc_d    = '0;
      end else begin
        flash_d = flash_q;
        fc_d    = fc_q + 1'b1;
      end
    end
  end

  // Control registers; reset drops any pending request and clears the fault.
  always_ff @(posedge clk) begin
    if (rst) begin
      t_q     <= 1'b1;
      pend_q  <= 1'b0;
      wd_q    <= '0;
      flash_q <= 1'b1;
      fc_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      t_q     <= t_d;
      pend_q  <= pend_d;
      wd_q    <= wd_d;
      flash_q <= flash_d;
      fc_q    <= fc_d;
      fault_q <= fault_d;
    end
  end

  // Lamp decode straight from registers so the lamps never glitch.
  always_comb begin
    main_rgy = 3'b100;
    side_rgy = 3'b100;
    walk     = 1'b0;
    case (state_q)
      S_MAIN_G: main_rgy = 3'b001;
      S_MAIN_Y: main_rgy = 3'b010;
      S_SIDE_G: begin side_rgy = 3'b001; walk = 1'b1; end
      S_SIDE_Y: side_rgy = 3'b010;
      S_FAULT:  begin main_rgy = {flash_q, 2'b00}; side_rgy = {flash_q, 2'b00}; end
      default:  ;
    endcase
  end

  assign T     = t_q;
  assign fault = fault_q;
  assign state = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl with a simple interval-counter model.
module tb_traffic_light_ctrl;

  logic       clk = 1'b0;
  logic       rst, side_req;
  logic       tr, tg_main, tg_small, ty;
  logic       T, walk, fault;
  logic [2:0] main_rgy, side_rgy, state;

  logic use_model;
  logic f_tr, f_tg_main, f_tg_small, f_ty;
  int   cnt = 0;
  int   checks = 0;
  int   errors = 0;

  traffic_light_ctrl #(.WDOG_CYCLES(64), .FLASH_HALF(8)) dut (
    .clk(clk), .rst(rst), .tr(tr), .tg_main(tg_main), .tg_small(tg_small),
    .ty(ty), .side_req(side_req), .T(T), .main_rgy(main_rgy),
    .side_rgy(side_rgy), .walk(walk), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  // Counter model: cleared by T, flags are levels once the interval has elapsed.
  always @(posedge clk) begin
    if (rst || T) cnt <= 0;
    else if (cnt < 1000) cnt <= cnt + 1;
  end

  assign tr       = use_model ? (cnt >= 2) : f_tr;
  assign ty       = use_model ? (cnt >= 3) : f_ty;
  assign tg_main  = use_model ? (cnt >= 5) : f_tg_main;
  assign tg_small = use_model ? (cnt >= 6) : f_tg_small;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected state in cycle k after reset release for the model-driven cycle.
  function automatic logic [2:0] exp_st(input int k, input bit r2);
    if (k < 12)             return 3'd0;
    else if (k < 17)        return 3'd1;
    else if (k < 21)        return 3'd2;
    else if (k < 29)        return 3'd3;
    else if (k < 34)        return 3'd4;
    else if (k < 38)        return 3'd5;
    else if (r2 && k >= 45) return 3'd1;
    else                    return 3'd0;
  endfunction

  function automatic logic exp_t(input int k, input bit r2);
    return (k == 12 || k == 17 || k == 21 || k == 29 || k == 34 || k == 38 ||
            (r2 && k == 45));
  endfunction

  function automatic logic [2:0] exp_main(input logic [2:0] s);
    case (s)
      3'd0:    return 3'b001;
      3'd1:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] exp_side(input logic [2:0] s);
    case (s)
      3'd3:    return 3'b001;
      3'd4:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 8'(state), 8'd0);
    chk({tag, "_T"}, 8'(T), 8'd1);
    chk({tag, "_main"}, 8'(main_rgy), 8'b001);
    chk({tag, "_side"}, 8'(side_rgy), 8'b100);
    chk({tag, "_walk"}, 8'(walk), 8'd0);
    chk({tag, "_fault"}, 8'(fault), 8'd0);
  endtask

  initial begin
    rst = 1'b1; side_req = 1'b0; use_model = 1'b0;
    f_tr = 1'b0; f_tg_main = 1'b0; f_tg_small = 1'b0; f_ty = 1'b0;

    // Reset held two cycles, then release: one more T cycle, then T drops.
    step(); step();
    chk_reset_vals("rst");
    rst = 1'b0;
    chk("rel_T_entry", 8'(T), 8'd1);
    step();
    chk("rel_T_drop", 8'(T), 8'd0);
    chk("rel_state", 8'(state), 8'd0);

    // Idle hold without demand, minimum green long served.
    f_tg_main = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      chk($sformatf("hold_state_%0d", i), 8'(state), 8'd0);
      chk($sformatf("hold_T_%0d", i), 8'(T), 8'd0);
      chk($sformatf("hold_fault_%0d", i), 8'(fault), 8'd0);
    end

    // Pulse with tg_main already high; ty held high through the MAIN_Y T cycle.
    f_ty = 1'b1;
    side_req = 1'b1;
    step();
    side_req = 1'b0;
    chk("pulse_n1_state", 8'(state), 8'd0);
    chk("pulse_n1_T", 8'(T), 8'd0);
    step();
    chk("pulse_n2_state", 8'(state), 8'd1);
    chk("pulse_n2_T", 8'(T), 8'd1);
    chk("pulse_n2_main", 8'(main_rgy), 8'b010);
    step();
    chk("stale_state", 8'(state), 8'd1);
    chk("stale_T", 8'(T), 8'd0);
    step();
    chk("stale_next_state", 8'(state), 8'd2);
    chk("stale_next_T", 8'(T), 8'd1);
    chk("stale_next_main", 8'(main_rgy), 8'b100);
    f_ty = 1'b0; f_tg_main = 1'b0;

    // Full cycle from the counter model; second run adds a request on the SIDE_G entry edge.
    use_model = 1'b1;
    for (int run = 0; run < 2; run++) begin
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int k = 1; k <= (run == 1 ? 45 : 50); k++) begin
        step();
        side_req = (k == 10) || (run == 1 && k == 20);
        chk($sformatf("cyc%0d_state_%0d", run, k), 8'(state), 8'(exp_st(k, run == 1)));
        chk($sformatf("cyc%0d_T_%0d", run, k), 8'(T), 8'(exp_t(k, run == 1)));
        chk($sformatf("cyc%0d_main_%0d", run, k), 8'(main_rgy), 8'(exp_main(exp_st(k, run == 1))));
        chk($sformatf("cyc%0d_side_%0d", run, k), 8'(side_rgy), 8'(exp_side(exp_st(k, run == 1))));
        chk($sformatf("cyc%0d_walk_%0d", run, k), 8'(walk), 8'(exp_st(k, run == 1) == 3'd3));
      end
    end
    side_req = 1'b0;

    // Watchdog: now in the MAIN_Y entry cycle, ty never arrives.
    use_model = 1'b0;
    repeat (64) step();
    chk("wd_last_state", 8'(state), 8'd1);
    chk("wd_last_fault", 8'(fault), 8'd0);
    step();
    chk("fault_state", 8'(state), 8'd6);
    chk("fault_flag", 8'(fault), 8'd1);
    chk("fault_T", 8'(T), 8'd0);
    chk("fault_walk", 8'(walk), 8'd0);
    chk("flash_f0_main", 8'(main_rgy), 8'b100);
    chk("flash_f0_side", 8'(side_rgy), 8'b100);
    side_req = 1'b1;
    step();
    side_req = 1'b0;
    repeat (6) step();
    chk("flash_f7_main", 8'(main_rgy), 8'b100);
    step();
    chk("flash_f8_main", 8'(main_rgy), 8'b000);
    chk("flash_f8_side", 8'(side_rgy), 8'b000);
    chk("flash_f8_T", 8'(T), 8'd0);
    repeat (7) step();
    chk("flash_f15_main", 8'(main_rgy), 8'b000);
    step();
    chk("flash_f16_main", 8'(main_rgy), 8'b100);
    chk("flash_f16_state", 8'(state), 8'd6);
    chk("flash_f16_fault", 8'(fault), 8'd1);

    // Reset out of FAULT restores reset values and drops the pending request.
    rst = 1'b1;
    step();
    chk_reset_vals("frst");
    rst = 1'b0;
    f_tg_main = 1'b1;
    step();
    chk("frst_T_drop", 8'(T), 8'd0);
    repeat (10) step();
    chk("frst_no_pend_state", 8'(state), 8'd0);
    chk("frst_no_pend_fault", 8'(fault), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
